// File: rtl/ldst_sequencer_pkg.sv
// Shared constants for the byte-serial load/store sequencer.
package ldst_sequencer_pkg;

  localparam int BYTE_W = 8;

  // Sequencer states: accept in IDLE, one byte per XFER cycle,
  // WAIT absorbs the last read-data latency, RESP is the completion pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/ldst_sequencer_if.sv
// Request/response and byte-memory signals of the load/store sequencer.
interface ldst_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_is_store;
  logic [1:0]            req_nbytes;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;

  // Sequencer side
  modport slave (
    input  req_valid, req_is_store, req_nbytes, req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_rdata, busy
  );

  // Pipeline + byte memory side
  modport master (
    output req_valid, req_is_store, req_nbytes, req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/ldst_sequencer.sv
// Splits a 1..4 byte load/store into single-byte memory accesses and
// assembles little-endian, optionally sign-extended load data.
module ldst_sequencer
  import ldst_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic              CLK,
  input  logic              RST,
  ldst_sequencer_if.slave   bus
);

  state_t                state_q, state_d;
  logic [1:0]            cnt_q;
  logic [1:0]            nbytes_q;
  logic                  is_store_q;
  logic                  signed_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rd_pend_q;
  logic [1:0]            rd_idx_q;
  logic [31:0]           asm_q;
  logic [31:0]           merged;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  accept;

  // Keep the low N bytes, fill everything above with the top kept bit or 0.
  function automatic logic [DATA_WIDTH-1:0] extend(input logic [31:0] raw,
                                                   input logic [1:0]  nb,
                                                   input logic        sgn);
    logic [DATA_WIDTH-1:0] r;
    logic                  fill;
    r    = '0;
    fill = sgn & raw[BYTE_W*int'(nb) + BYTE_W - 1];
    for (int i = 0; i < 4; i++)
      r[BYTE_W*i +: BYTE_W] = (i <= int'(nb)) ? raw[BYTE_W*i +: BYTE_W] : {BYTE_W{fill}};
    for (int i = 32; i < DATA_WIDTH; i++) r[i] = fill;
    return r;
  endfunction

  assign accept        = bus.req_valid && (state_q == IDLE);
  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_en    = (state_q == XFER);
  assign bus.mem_we    = (state_q == XFER) && is_store_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q[BYTE_W*int'(cnt_q) +: BYTE_W];
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;

  // Read byte returns one cycle after its strobe; fold it into the assembly word.
  always_comb begin
    merged = asm_q;
    if (rd_pend_q) merged[BYTE_W*int'(rd_idx_q) +: BYTE_W] = bus.mem_rdata;
  end

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = XFER;
      XFER: if (cnt_q == nbytes_q) state_d = WAIT;
      WAIT: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, byte counter, address incrementer and load assembly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q      <= '0;
      nbytes_q   <= '0;
      is_store_q <= 1'b0;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= '0;
      asm_q      <= '0;
      rdata_q    <= '0;
    end else begin
      rd_pend_q <= (state_q == XFER) && !is_store_q;
      rd_idx_q  <= cnt_q;
      asm_q     <= merged;
      case (state_q)
        IDLE: if (accept) begin
          cnt_q      <= '0;
          nbytes_q   <= bus.req_nbytes;
          is_store_q <= bus.req_is_store;
          signed_q   <= bus.req_signed;
          addr_q     <= bus.req_addr;
          wdata_q    <= bus.req_wdata;
        end
        XFER: begin
          cnt_q  <= cnt_q + 2'd1;
          addr_q <= addr_q + 1'b1;
        end
        // Last load byte arrives here, so the response word is built from merged.
        WAIT: rdata_q <= is_store_q ? '0 : extend(merged, nbytes_q, signed_q);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ldst_sequencer.sv
// Directed bench for ldst_sequencer: vector table plus hold-valid and reset-abort sequences.
module tb_ldst_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldst_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  ldst_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Byte memory model, 1 KiB window on addr[9:0]; read data one cycle after strobe.
  logic [7:0] mem [1024] = '{default: 8'h00};
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[9:0]];
    end
  end

  typedef struct {
    logic        st;
    logic [1:0]  nb;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [1:0] nb, input logic sg,
                       input logic [31:0] a, input logic [31:0] w);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_nbytes   = nb;
    bus.req_signed   = sg;
    bus.req_addr     = a;
    bus.req_wdata    = w;
  endtask

  // One transaction from accept to the IDLE cycle after RESP, checked every cycle.
  task automatic run_vec(input vec_t v);
    logic [31:0] a, w;
    @(negedge clk);
    drive(v.st, v.nb, v.sg, v.addr, v.wdata);
    chk("ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Garbage on the request inputs must be ignored while busy.
    bus.req_valid    = 1'b0;
    bus.req_is_store = ~v.st;
    bus.req_nbytes   = ~v.nb;
    bus.req_signed   = ~v.sg;
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    for (int k = 0; k <= int'(v.nb); k++) begin
      @(negedge clk);
      a = v.addr + 32'(k);
      w = v.wdata >> (8 * k);
      chk("xfer_en",   32'(bus.mem_en), 32'd1);
      chk("xfer_we",   32'(bus.mem_we), 32'(v.st));
      chk("xfer_addr", bus.mem_addr, a);
      if (v.st) chk("xfer_wdata", 32'(bus.mem_wdata), 32'(w[7:0]));
    end
    @(negedge clk);
    chk("wait_en",  32'(bus.mem_en), 32'd0);
    chk("wait_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("wait_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("resp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("resp_rdata", bus.rsp_rdata, v.exp);
    chk("resp_en",    32'(bus.mem_en), 32'd0);
    @(negedge clk);
    chk("post_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_ready", 32'(bus.req_ready), 32'd1);
    chk("post_hold",  bus.rsp_rdata, v.exp);
  endtask

  initial begin
    //             st    nb     sg    addr          wdata         exp
    tbl[0]  = '{1'b1, 2'd3, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000};
    tbl[1]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
    tbl[2]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0101, 32'h0,         32'hFFFF_ADBE};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'h00AD_BEEF};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0020, 32'h1234_5680, 32'h0000_0000};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0020, 32'h0,         32'hFFFF_FF80};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0080};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0000_0000};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0000_1234};
    tbl[9]  = '{1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h0000_1234};
    tbl[10] = '{1'b1, 2'd2, 1'b1, 32'h0000_0200, 32'hAA81_7F01, 32'h0000_0000};
    tbl[11] = '{1'b0, 2'd2, 1'b1, 32'h0000_0200, 32'h0,         32'hFF81_7F01};
    tbl[12] = '{1'b0, 2'd3, 1'b1, 32'h0000_0200, 32'h0,         32'h0081_7F01};

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_nbytes = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_en",    32'(bus.mem_en), 32'd0);
    chk("rst_we",    32'(bus.mem_we), 32'd0);
    chk("rst_addr",  bus.mem_addr, 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_rsp",   32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    // req_valid held high: accepts only in IDLE, 1-byte load has N+2 = 3 busy cycles.
    @(negedge clk);
    drive(1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0);
    chk("hold_ready_t0", 32'(bus.req_ready), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_busy",  32'(bus.busy), 32'd1);
      chk("hold_rsp",   32'(bus.rsp_valid), (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) chk("hold_rdata", bus.rsp_rdata, 32'h0000_0080);
    end
    @(negedge clk);
    chk("hold_ready_2nd", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("hold_2nd_en",   32'(bus.mem_en), 32'd1);
    chk("hold_2nd_addr", bus.mem_addr, 32'h0000_0020);
    repeat (3) @(negedge clk);
    chk("hold_2nd_idle", 32'(bus.req_ready), 32'd1);

    // Reset during byte 1 of a 4-byte store aborts it.
    drive(1'b1, 2'd3, 1'b0, 32'h0000_0300, 32'h1122_3344);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_en_t1",   32'(bus.mem_en), 32'd1);
    chk("abort_addr_t1", bus.mem_addr, 32'h0000_0300);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_en",  32'(bus.mem_en), 32'd0);
      chk("abort_rsp", 32'(bus.rsp_valid), 32'd0);
      if (c == 0) begin
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_rdata", bus.rsp_rdata, 32'd0);
      end
    end

    // Reset wins over a simultaneous request.
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("prio_busy", 32'(bus.busy), 32'd0);
    chk("prio_en",   32'(bus.mem_en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
